// File: rtl/trisc_pkg.sv
// Shared types and constants for the TRISC control sequencer.
// Holds the FSM state enum, ALU select codes, decoder bit indices and a one-hot check.
package trisc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        F1,
        F2,
        DEC,
        EXR,
        EXW,
        HALT
    } state_e;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_XOR  = 2'b11;

    localparam int IDX_LDA = 0;
    localparam int IDX_SAT = 1;
    localparam int IDX_ADD = 2;
    localparam int IDX_SUB = 3;
    localparam int IDX_XOR = 4;
    localparam int IDX_INC = 5;
    localparam int IDX_CLR = 6;
    localparam int IDX_JMP = 7;
    localparam int IDX_JPZ = 8;
    localparam int IDX_JPN = 9;
    localparam int IDX_HLT = 10;

    localparam int DEC_W = 11;

    // True when exactly one decoder line is active.
    function automatic logic onehot11(input logic [DEC_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < DEC_W; i++) begin
            n += int'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/trisc_control_sequencer_if.sv
// Decoder/datapath <-> sequencer bundle: decoded lines and flags in, strobes out.
// master: decoder/datapath side (drives dec_lines, flags); slave: the sequencer.
interface trisc_control_sequencer_if;
    import trisc_pkg::*;

    logic [DEC_W-1:0] dec_lines;
    logic             n_flag;
    logic             z_flag;

    logic             mar_ld_pc;
    logic             mar_ld_ir;
    logic             ir_ld;
    logic             pc_inc;
    logic             pc_ld;
    logic             mem_rd;
    logic             mem_wr;
    logic             acc_ld;
    logic             acc_clr;
    logic             acc_inc;
    logic [1:0]       alu_sel;

    modport master (
        output dec_lines, n_flag, z_flag,
        input  mar_ld_pc, mar_ld_ir, ir_ld, pc_inc, pc_ld,
        input  mem_rd, mem_wr, acc_ld, acc_clr, acc_inc, alu_sel
    );

    modport slave (
        input  dec_lines, n_flag, z_flag,
        output mar_ld_pc, mar_ld_ir, ir_ld, pc_inc, pc_ld,
        output mem_rd, mem_wr, acc_ld, acc_clr, acc_inc, alu_sel
    );

endinterface

// File: rtl/trisc_control_sequencer.sv
// TRISC control unit: fetch/decode/execute FSM driving all datapath strobes.
// Ports: clk, rst_n, start, bus (slave: dec_lines/flags in, strobes out), halted, illegal, instr_cnt.
module trisc_control_sequencer
    import trisc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    trisc_control_sequencer_if.slave bus,
    output logic                    halted,
    output logic                    illegal,
    output logic [CNT_W-1:0]        instr_cnt
);

    state_e             state_q;
    logic [DEC_W-1:0]   op_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               legal;
    logic               rd_op;
    logic               wr_op;
    logic               retire;

    always_comb begin
        legal = onehot11(bus.dec_lines);
        rd_op = bus.dec_lines[IDX_LDA] | bus.dec_lines[IDX_ADD]
              | bus.dec_lines[IDX_SUB] | bus.dec_lines[IDX_XOR];
        wr_op = bus.dec_lines[IDX_SAT];
    end

    // Memory ops retire in their execute state, everything else
    // legal (including HLT) retires straight out of DEC.
    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            DEC:      retire = legal & ~rd_op & ~wr_op;
            EXR, EXW: retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) state_q <= F1;
                end
                F1:  state_q <= F2;
                F2:  state_q <= DEC;
                DEC: begin
                    op_q <= bus.dec_lines;
                    if (!legal) begin
                        illegal_q <= 1'b1;
                        state_q   <= HALT;
                    end else if (bus.dec_lines[IDX_HLT]) begin
                        state_q <= HALT;
                    end else if (rd_op) begin
                        state_q <= EXR;
                    end else if (wr_op) begin
                        state_q <= EXW;
                    end else begin
                        state_q <= F1;
                    end
                end
                EXR, EXW: state_q <= F1;
                HALT: begin
                    if (start) begin
                        illegal_q <= 1'b0;
                        state_q   <= F1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (retire && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Strobes decode from the registered state; DEC additionally looks at
    // the live decoder lines and flags, so it is gated by legality.
    always_comb begin
        bus.mar_ld_pc = 1'b0;
        bus.mar_ld_ir = 1'b0;
        bus.ir_ld     = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.pc_ld     = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.acc_ld    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.acc_inc   = 1'b0;
        bus.alu_sel   = ALU_PASS;
        unique case (state_q)
            F1: bus.mar_ld_pc = 1'b1;
            F2: begin
                bus.mem_rd = 1'b1;
                bus.ir_ld  = 1'b1;
                bus.pc_inc = 1'b1;
            end
            DEC: begin
                if (legal) begin
                    unique case (1'b1)
                        rd_op, wr_op:               bus.mar_ld_ir = 1'b1;
                        bus.dec_lines[IDX_INC]:     bus.acc_inc   = 1'b1;
                        bus.dec_lines[IDX_CLR]:     bus.acc_clr   = 1'b1;
                        bus.dec_lines[IDX_JMP]:     bus.pc_ld     = 1'b1;
                        bus.dec_lines[IDX_JPZ]:     bus.pc_ld     = bus.z_flag;
                        bus.dec_lines[IDX_JPN]:     bus.pc_ld     = bus.n_flag;
                        default: ;
                    endcase
                end
            end
            EXR: begin
                bus.mem_rd = 1'b1;
                bus.acc_ld = 1'b1;
                unique case (1'b1)
                    op_q[IDX_ADD]: bus.alu_sel = ALU_ADD;
                    op_q[IDX_SUB]: bus.alu_sel = ALU_SUB;
                    op_q[IDX_XOR]: bus.alu_sel = ALU_XOR;
                    default:       bus.alu_sel = ALU_PASS;
                endcase
            end
            EXW: bus.mem_wr = 1'b1;
            default: ;
        endcase
    end

    assign halted    = (state_q == HALT);
    assign illegal   = illegal_q;
    assign instr_cnt = cnt_q;

endmodule
